// File: rtl/controle_exibicao_leds_pkg.sv
// Shared definitions for the LED display sequencer: state codes,
// default timing and the timer width helper.
package controle_exibicao_leds_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        LIGA    = 3'd2,
        DESLIGA = 3'd3,
        AVANCA  = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam int T_ON_PADRAO  = 1000;
    localparam int T_OFF_PADRAO = 500;

    // A single-value timer still needs one bit so the vector is legal.
    function automatic int largura_timer(input int t_on, input int t_off);
        int maior;
        maior = (t_on > t_off) ? t_on : t_off;
        return (maior > 1) ? $clog2(maior) : 1;
    endfunction

endpackage

// File: rtl/controle_exibicao_leds_contador_tempo.sv
// Generic modulo-M counter used as the on/off timer of the LED sequencer.
module contador_tempo #(
    parameter int M = 8,
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] valor,
    output logic         fim
);

    assign fim = (valor == W'(M - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            if (fim) valor <= '0;
            else     valor <= valor + W'(1);
        end
    end

endmodule

// File: rtl/controle_exibicao_leds.sv
// Control unit that walks item addresses 0..nivel, lighting the LED for
// T_ON cycles and leaving it dark for T_OFF cycles per item.
module controle_exibicao_leds
    import controle_exibicao_leds_pkg::*;
#(
    parameter int T_ON   = T_ON_PADRAO,
    parameter int T_OFF  = T_OFF_PADRAO,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic [ADDR_W-1:0] nivel,
    output logic [ADDR_W-1:0] endereco,
    output logic              liga_led,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = largura_timer(T_ON, T_OFF);

    estado_t           estado;
    estado_t           proximo;
    logic [TW-1:0]     tempo;
    logic              tempo_fim;
    logic              fim_liga;
    logic              fim_desliga;
    logic              expira;
    logic              zera;
    logic              conta;
    logic [ADDR_W-1:0] nivel_reg;

    contador_tempo #(
        .M (T_MAX),
        .W (TW)
    ) u_contador_tempo (
        .clock (clock),
        .reset (reset),
        .zera  (zera),
        .conta (conta),
        .valor (tempo),
        .fim   (tempo_fim)
    );

    // The timer wraps at the longer interval; the shorter one is decoded here.
    assign fim_liga    = (T_ON  == T_MAX) ? tempo_fim : (tempo == TW'(T_ON  - 1));
    assign fim_desliga = (T_OFF == T_MAX) ? tempo_fim : (tempo == TW'(T_OFF - 1));

    always_comb begin
        expira = 1'b0;
        case (estado)
            LIGA:    expira = fim_liga;
            DESLIGA: expira = fim_desliga;
            default: expira = 1'b0;
        endcase
        conta = (estado == LIGA) || (estado == DESLIGA);
        zera  = !conta || expira || abortar;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        if (abortar && (estado != OCIOSO)) begin
            proximo = OCIOSO;
        end else begin
            case (estado)
                OCIOSO:  if (iniciar) proximo = PREPARA;
                PREPARA: proximo = LIGA;
                LIGA:    if (expira) proximo = DESLIGA;
                DESLIGA: if (expira) proximo = (endereco == nivel_reg) ? FIM : AVANCA;
                AVANCA:  proximo = LIGA;
                FIM:     proximo = OCIOSO;
                default: proximo = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco  <= '0;
            nivel_reg <= '0;
        end else begin
            case (estado)
                PREPARA: begin
                    endereco  <= '0;
                    nivel_reg <= nivel;
                end
                AVANCA:  endereco <= endereco + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign liga_led  = (estado == LIGA);
    assign ocupado   = (estado != OCIOSO);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

endmodule

// File: tb/tb_controle_exibicao_leds.sv
// Randomized self-checking bench for controle_exibicao_leds against a
// cycle-trace model built from the item timing rules.
module tb_controle_exibicao_leds;

    localparam int T_ON   = 3;
    localparam int T_OFF  = 2;
    localparam int ADDR_W = 4;

    logic              clock;
    logic              reset;
    logic              iniciar;
    logic              abortar;
    logic [ADDR_W-1:0] nivel;
    logic [ADDR_W-1:0] endereco;
    logic              liga_led;
    logic              ocupado;
    logic              pronto;
    logic [2:0]        db_estado;

    int checks = 0;
    int errors = 0;

    int exp_est[$];
    int exp_end[$];

    controle_exibicao_leds #(
        .T_ON   (T_ON),
        .T_OFF  (T_OFF),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .abortar   (abortar),
        .nivel     (nivel),
        .endereco  (endereco),
        .liga_led  (liga_led),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected per-cycle state code and address, starting with the cycle after the start edge.
    task automatic build_model(input int n);
        exp_est.delete();
        exp_end.delete();
        exp_est.push_back(1); exp_end.push_back(0);
        for (int item = 0; item <= n; item++) begin
            for (int c = 0; c < T_ON; c++)  begin exp_est.push_back(2); exp_end.push_back(item); end
            for (int c = 0; c < T_OFF; c++) begin exp_est.push_back(3); exp_end.push_back(item); end
            if (item < n) begin exp_est.push_back(4); exp_end.push_back(item); end
        end
        exp_est.push_back(5); exp_end.push_back(n);
    endtask

    task automatic start_run(input int n);
        @(negedge clock);
        nivel   = ADDR_W'(n);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        iniciar = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; nivel = '0;
        #12;
        checks++;
        if ({db_estado, liga_led, ocupado, pronto, endereco} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b expected %b",
                     {db_estado, liga_led, ocupado, pronto, endereco}, 10'b0);
        end
        @(negedge clock);
        reset   = 1'b0;
        abortar = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        abortar = 1'b0;
        checks++;
        if ({db_estado, ocupado, pronto} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", {db_estado, ocupado, pronto}, 5'b0);
        end
    endtask

    // noise: 0 quiet, 1 random iniciar/nivel while busy, 2 iniciar=1 and nivel=5 while busy
    task automatic test_sequence(input int n, input int noise);
        logic [5:0] obs;
        logic [5:0] expv;
        logic [2:0] c;
        int pronto_idx;
        int pronto_cnt;
        int n_items;
        build_model(n);
        start_run(n);
        pronto_idx = -1;
        pronto_cnt = 0;
        for (int i = 0; i < exp_est.size(); i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            c    = 3'(exp_est[i]);
            obs  = {db_estado, liga_led, ocupado, pronto};
            expv = {c, c == 3'd2, c != 3'd0, c == 3'd5};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("[TB] FAIL seq_n%0d_cycle%0d: got %b expected %b", n, i + 1, obs, expv);
            end
            if (c >= 3'd2) begin
                checks++;
                if (endereco !== ADDR_W'(exp_end[i])) begin
                    errors++;
                    $display("[TB] FAIL addr_n%0d_cycle%0d: got %0d expected %0d", n, i + 1, endereco, exp_end[i]);
                end
            end
            if (pronto === 1'b1) begin pronto_idx = i + 1; pronto_cnt++; end
            if (i >= 1 && i < exp_est.size() - 1) begin
                if (noise == 1) begin
                    iniciar = 1'($urandom_range(0, 1));
                    nivel   = ADDR_W'($urandom);
                end else if (noise == 2) begin
                    iniciar = 1'b1;
                    nivel   = ADDR_W'(5);
                end
            end
        end
        iniciar = 1'b0;
        n_items = n + 1;
        checks++;
        if (pronto_idx != 2 + n_items * (T_ON + T_OFF) + (n_items - 1) || pronto_cnt != 1) begin
            errors++;
            $display("[TB] FAIL pronto_latency_n%0d: got cycle %0d (count %0d) expected cycle %0d (count 1)",
                     n, pronto_idx, pronto_cnt, 2 + n_items * (T_ON + T_OFF) + (n_items - 1));
        end
        @(posedge clock); #1;
        checks++;
        if ({db_estado, liga_led, ocupado, pronto, endereco} !== {6'b0, ADDR_W'(n)}) begin
            errors++;
            $display("[TB] FAIL idle_after_n%0d: got %b expected %b",
                     n, {db_estado, liga_led, ocupado, pronto, endereco}, {6'b0, ADDR_W'(n)});
        end
    endtask

    task automatic test_abort(input int n, input int pos);
        build_model(n);
        start_run(n);
        for (int i = 0; i <= pos; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            checks++;
            if (db_estado !== 3'(exp_est[i])) begin
                errors++;
                $display("[TB] FAIL abort_pre_state_cycle%0d: got %0d expected %0d", i + 1, db_estado, exp_est[i]);
            end
        end
        abortar = 1'b1;
        @(posedge clock); #1;
        abortar = 1'b0;
        checks++;
        if ({db_estado, liga_led, ocupado, pronto} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL abort_pos%0d: got %b expected %b", pos, {db_estado, liga_led, ocupado, pronto}, 6'b0);
        end
        for (int i = 0; i < 2 * (T_ON + T_OFF); i++) begin
            @(posedge clock); #1;
            checks++;
            if ({ocupado, pronto, liga_led} !== 3'b0) begin
                errors++;
                $display("[TB] FAIL abort_stays_idle_%0d: got %b expected %b", i, {ocupado, pronto, liga_led}, 3'b0);
            end
        end
    endtask

    task automatic test_async_reset();
        start_run(1);
        for (int i = 1; i < 1 + T_ON + 1; i++) begin @(posedge clock); #1; end
        checks++;
        if (db_estado !== 3'd3) begin
            errors++;
            $display("[TB] FAIL async_reset_setup: got %0d expected %0d", db_estado, 3);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({db_estado, liga_led, ocupado, pronto, endereco} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_immediate: got %b expected %b",
                     {db_estado, liga_led, ocupado, pronto, endereco}, 10'b0);
        end
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2 * (T_ON + T_OFF); i++) begin
            @(posedge clock); #1;
            checks++;
            if ({db_estado, ocupado, pronto} !== 5'b0) begin
                errors++;
                $display("[TB] FAIL after_async_reset_%0d: got %b expected %b", i, {db_estado, ocupado, pronto}, 5'b0);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            test_sequence(int'($urandom_range(0, 15)), 1);
        end
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(0, 4));
            test_abort(n, int'($urandom_range(0, n * (T_ON + T_OFF + 1) + T_ON + T_OFF)));
            test_sequence(int'($urandom_range(0, 3)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_sequence(2, 0);
        test_sequence(0, 0);
        test_sequence(15, 0);
        test_abort(2, 1 + T_ON + T_OFF + 1);
        test_sequence(1, 0);
        test_sequence(2, 2);
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_exibicao_leds.md
CONTROLE_EXIBICAO_LEDS -- requirements
Module: controle_exibicao_leds

Interface
REQ-001 Parameter T_ON, 1000, LED-on time per item, in clock cycles (>=1).
REQ-002 Parameter T_OFF, 500, LED-off gap after each item, in clock cycles (>=1).
REQ-003 Parameter ADDR_W, 4, width of the item address and of nivel.
REQ-004 Port clock  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port iniciar  input  1  start request, sampled only in OCIOSO.
REQ-007 Port abortar  input  1  cancel the running sequence.
REQ-008 Port nivel  input  ADDR_W  index of the last item to show (inclusive), captured at start.
REQ-009 Port endereco  output  ADDR_W  item address driven to the sequence ROM.
REQ-010 Port liga_led  output  1  LED enable for the item at endereco.
REQ-011 Port ocupado  output  1  high in every state except OCIOSO.
REQ-012 Port pronto  output  1  one-cycle pulse when a sequence completes normally.
REQ-013 Port db_estado  output  3  current state code, for debug.

Function
REQ-014 Moore FSM states and codes: OCIOSO=0, PREPARA=1, LIGA=2, DESLIGA=3, AVANCA=4, FIM=5.
REQ-015 OCIOSO: iniciar=1 -> PREPARA; otherwise stay in OCIOSO.
REQ-016 PREPARA (1 cycle): capture nivel into nivel_reg, zero endereco and the timer, go to LIGA.
REQ-017 LIGA: liga_led=1 for exactly T_ON cycles, then go to DESLIGA with the timer zeroed.
REQ-018 DESLIGA: liga_led=0 for exactly T_OFF cycles; at expiry go to FIM if endereco==nivel_reg, else to AVANCA.
REQ-019 AVANCA (1 cycle): endereco <= endereco+1, timer zeroed, go to LIGA.
REQ-020 FIM (1 cycle): pronto=1, then go to OCIOSO.
REQ-021 Latency: with iniciar sampled at edge k, liga_led rises at cycle k+2, and pronto is at cycle k+2+N*(T_ON+T_OFF)+(N-1), where N=nivel+1.
REQ-022 abortar=1 in any state other than OCIOSO -> OCIOSO on the next edge; no pronto; liga_led low from that cycle on.
REQ-023 abortar has priority over iniciar; abortar in OCIOSO has no effect.
REQ-024 iniciar while ocupado=1 is ignored; changes on nivel after PREPARA are ignored.
REQ-025 nivel=0 shows exactly one item (address 0).
REQ-026 nivel=2^ADDR_W-1 shows every address; endereco never wraps (FIM is taken at the maximum address).
REQ-027 endereco holds its value in OCIOSO and FIM and is only modified in PREPARA and AVANCA.
REQ-028 Timer width is clog2(max(T_ON,T_OFF)); the timer counts only in LIGA and DESLIGA.

Reset
REQ-029 Asynchronous reset: state=OCIOSO, endereco=0, nivel_reg=0, timer=0.
REQ-030 During reset: liga_led=0, ocupado=0, pronto=0, db_estado=0.
REQ-031 Reset mid-sequence aborts immediately with no pronto; the first cycle after release is OCIOSO.

Structure
REQ-032 A shared package holds the state encoding constants and the T_ON/T_OFF defaults, also used by the top-level control unit.
REQ-033 A single sub-module, contador_tempo, provides the timer: generic modulo-M counter with zera, conta and fim (fim=1 at M-1).
REQ-034 The item address counter and nivel_reg live in controle_exibicao_leds itself.

Verification
REQ-035 T_ON=3, T_OFF=2, nivel=2, iniciar at edge k -> liga_led high at k+2..k+4, k+8..k+10, k+14..k+16; endereco 0,1,2; pronto only at k+19.
REQ-036 nivel=0 -> one on-pulse of T_ON cycles at endereco=0; pronto at k+2+T_ON+T_OFF.
REQ-037 nivel=15 (ADDR_W=4) -> 16 on-pulses, endereco 0..15 with no wrap, then a single pronto.
REQ-038 abortar asserted in the second LIGA -> OCIOSO next cycle, liga_led=0, ocupado=0, no pronto; a later iniciar restarts at endereco=0.
REQ-039 iniciar pulsed mid-sequence with nivel changed from 2 to 5 -> no effect; the sequence still ends after 3 items.
REQ-040 Asynchronous reset asserted in DESLIGA between edges -> outputs reach reset values without waiting for a clock edge; state OCIOSO after release.
